// File: rtl/pulse_rate_counter.sv
// pulse_rate_counter: gated event counter with non-paralyzable dead time and saturating totals
module pulse_rate_counter #(
    parameter int COUNT_W     = 16,
    parameter int GATE_CYCLES = 1000,
    parameter int DEAD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               pulse_in,
    output logic [COUNT_W-1:0] count_out,
    output logic [COUNT_W-1:0] lost_out,
    output logic               count_valid,
    output logic               overflow,
    output logic               dead_busy
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

    typedef enum logic {IDLE, GATING} state_t;

    state_t             state_q;
    logic               pulse_q;
    logic [DW-1:0]      dead_q, dead_d;
    logic [GW-1:0]      gate_q, gate_now;
    logic [COUNT_W-1:0] acc_cnt_q, acc_cnt_d, acc_lost_q, acc_lost_d;
    logic               sticky_cnt_q, sticky_cnt_d, sticky_lost_q, sticky_lost_d;
    logic [COUNT_W-1:0] count_q, lost_q;
    logic               valid_q, overflow_q;
    logic               rise, accept, lose, close;

    assign dead_busy   = |dead_q;
    assign count_out   = count_q;
    assign lost_out    = lost_q;
    assign count_valid = valid_q;
    assign overflow    = overflow_q;

    // Classify this cycle's edge and form saturating next values for the accumulators
    always_comb begin
        rise          = pulse_in & ~pulse_q;
        accept        = enable & rise & ~dead_busy;
        lose          = enable & rise & dead_busy;
        dead_d        = accept ? DEAD_LOAD : (dead_busy ? dead_q - DW'(1) : '0);
        gate_now      = (state_q == GATING) ? gate_q : '0;
        close         = enable & (gate_now == GATE_LAST);
        acc_cnt_d     = acc_cnt_q + COUNT_W'(accept & ~(&acc_cnt_q));
        acc_lost_d    = acc_lost_q + COUNT_W'(lose & ~(&acc_lost_q));
        sticky_cnt_d  = sticky_cnt_q | (accept & (&acc_cnt_q));
        sticky_lost_d = sticky_lost_q | (lose & (&acc_lost_q));
    end

    // Edge-detect history and dead timer run independently of the gate
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b0;
            dead_q  <= '0;
        end else begin
            pulse_q <= pulse_in;
            dead_q  <= dead_d;
        end
    end

    // Gate window sequencing, accumulation and publication of the window totals
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gate_q        <= '0;
            acc_cnt_q     <= '0;
            acc_lost_q    <= '0;
            sticky_cnt_q  <= 1'b0;
            sticky_lost_q <= 1'b0;
            count_q       <= '0;
            lost_q        <= '0;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            valid_q <= close;
            if (!enable) begin
                state_q       <= IDLE;
                gate_q        <= '0;
                acc_cnt_q     <= '0;
                acc_lost_q    <= '0;
                sticky_cnt_q  <= 1'b0;
                sticky_lost_q <= 1'b0;
            end else if (close) begin
                state_q       <= GATING;
                gate_q        <= '0;
                acc_cnt_q     <= '0;
                acc_lost_q    <= '0;
                sticky_cnt_q  <= 1'b0;
                sticky_lost_q <= 1'b0;
                count_q       <= acc_cnt_d;
                lost_q        <= acc_lost_d;
                overflow_q    <= sticky_cnt_d | sticky_lost_d;
            end else begin
                state_q       <= GATING;
                gate_q        <= gate_now + GW'(1);
                acc_cnt_q     <= acc_cnt_d;
                acc_lost_q    <= acc_lost_d;
                sticky_cnt_q  <= sticky_cnt_d;
                sticky_lost_q <= sticky_lost_d;
            end
        end
    end
endmodule

// File: tb/tb_pulse_rate_counter.sv
// tb_pulse_rate_counter: scenario tasks with a queue of expected window totals
module tb_pulse_rate_counter;
    logic       clk = 1'b0;
    logic       rst, en_a, p_a, en_b, p_b;
    logic [7:0] cnt_a, lost_a;
    logic       vld_a, ovf_a, busy_a;
    logic [3:0] cnt_b, lost_b;
    logic       vld_b, ovf_b, busy_b;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {int cnt; int lost; int ovf;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pulse_rate_counter #(.COUNT_W(8), .GATE_CYCLES(16), .DEAD_CYCLES(3)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .pulse_in(p_a),
        .count_out(cnt_a), .lost_out(lost_a), .count_valid(vld_a),
        .overflow(ovf_a), .dead_busy(busy_a)
    );

    pulse_rate_counter #(.COUNT_W(4), .GATE_CYCLES(64), .DEAD_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .pulse_in(p_b),
        .count_out(cnt_b), .lost_out(lost_b), .count_valid(vld_b),
        .overflow(ovf_b), .dead_busy(busy_b)
    );

    task automatic drive_a(input logic en, input logic p);
        en_a = en;
        p_a  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic en, input logic p);
        en_b = en;
        p_b  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) drive_a(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        exp_t e;
        rst = 1'b1; en_a = 1'b1; p_a = 1'b1; en_b = 1'b1; p_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({cnt_a, lost_a, vld_a, ovf_a, busy_a, cnt_b, lost_b, vld_b, ovf_b, busy_b} !== 29'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got a=%h/%h/%b/%b/%b b=%h/%h/%b/%b/%b want all 0",
                         cnt_a, lost_a, vld_a, ovf_a, busy_a, cnt_b, lost_b, vld_b, ovf_b, busy_b);
            end
        end
        rst = 1'b0; en_b = 1'b0; p_b = 1'b0;
        sb.push_back('{1, 0, 0});
        for (int c = 0; c <= 16; c++) begin
            n_cmp++;
            if (vld_a !== (c == 16)) begin
                n_bad++;
                $display("FAIL reset_strobe cyc%0d: got %b want %b", c, vld_a, c == 16);
            end
            if (c == 16) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL reset_sb: got empty queue want entry"); end
                else begin
                    e = sb.pop_front();
                    if ({cnt_a, lost_a, ovf_a} !== {e.cnt[7:0], e.lost[7:0], e.ovf[0]}) begin
                        n_bad++;
                        $display("FAIL reset_totals: got %0d/%0d/%b want %0d/%0d/%0d", cnt_a, lost_a, ovf_a, e.cnt, e.lost, e.ovf);
                    end
                end
            end
            drive_a(c < 16, c == 0);
        end
        idle_a(4);
    endtask

    task automatic test_basic;
        exp_t e;
        sb.push_back('{3, 0, 0});
        for (int c = 0; c <= 16; c++) begin
            n_cmp++;
            if (vld_a !== (c == 16)) begin
                n_bad++;
                $display("FAIL basic_strobe cyc%0d: got %b want %b", c, vld_a, c == 16);
            end
            if (c == 16) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL basic_sb: got empty queue want entry"); end
                else begin
                    e = sb.pop_front();
                    if ({cnt_a, lost_a, ovf_a} !== {e.cnt[7:0], e.lost[7:0], e.ovf[0]}) begin
                        n_bad++;
                        $display("FAIL basic_totals: got %0d/%0d/%b want %0d/%0d/%0d", cnt_a, lost_a, ovf_a, e.cnt, e.lost, e.ovf);
                    end
                end
            end
            drive_a(c < 16, c == 2 || c == 8 || c == 14);
        end
        idle_a(4);
    endtask

    task automatic test_dead_time;
        exp_t e;
        logic busy_exp;
        sb.push_back('{3, 1, 0});
        for (int c = 0; c <= 19; c++) begin
            busy_exp = (c >= 1 && c <= 3) || (c >= 5 && c <= 7) || (c >= 16 && c <= 18);
            n_cmp++;
            if (busy_a !== busy_exp) begin
                n_bad++;
                $display("FAIL dead_busy cyc%0d: got %b want %b", c, busy_a, busy_exp);
            end
            n_cmp++;
            if (vld_a !== (c == 16)) begin
                n_bad++;
                $display("FAIL dead_strobe cyc%0d: got %b want %b", c, vld_a, c == 16);
            end
            if (c == 16) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL dead_sb: got empty queue want entry"); end
                else begin
                    e = sb.pop_front();
                    if ({cnt_a, lost_a, ovf_a} !== {e.cnt[7:0], e.lost[7:0], e.ovf[0]}) begin
                        n_bad++;
                        $display("FAIL dead_totals: got %0d/%0d/%b want %0d/%0d/%0d", cnt_a, lost_a, ovf_a, e.cnt, e.lost, e.ovf);
                    end
                end
            end
            drive_a(c < 16, c == 0 || c == 2 || c == 4 || c == 15);
        end
        idle_a(2);
    endtask

    task automatic test_held_pulse;
        exp_t e;
        sb.push_back('{1, 0, 0});
        for (int c = 0; c <= 16; c++) begin
            n_cmp++;
            if (vld_a !== (c == 16)) begin
                n_bad++;
                $display("FAIL held_strobe cyc%0d: got %b want %b", c, vld_a, c == 16);
            end
            if (c == 16) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL held_sb: got empty queue want entry"); end
                else begin
                    e = sb.pop_front();
                    if ({cnt_a, lost_a, ovf_a} !== {e.cnt[7:0], e.lost[7:0], e.ovf[0]}) begin
                        n_bad++;
                        $display("FAIL held_totals: got %0d/%0d/%b want %0d/%0d/%0d", cnt_a, lost_a, ovf_a, e.cnt, e.lost, e.ovf);
                    end
                end
            end
            drive_a(c < 16, c >= 3 && c <= 9);
        end
        idle_a(4);
    endtask

    task automatic test_enable_abort;
        exp_t e;
        sb.push_back('{3, 0, 0});
        for (int c = 0; c <= 31; c++) begin
            n_cmp++;
            if (vld_a !== (c == 31)) begin
                n_bad++;
                $display("FAIL abort_strobe cyc%0d: got %b want %b", c, vld_a, c == 31);
            end
            if (c < 31) begin
                n_cmp++;
                if ({cnt_a, lost_a, ovf_a} !== {8'd1, 8'd0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL abort_hold cyc%0d: got %0d/%0d/%b want 1/0/0", c, cnt_a, lost_a, ovf_a);
                end
            end else begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL abort_sb: got empty queue want entry"); end
                else begin
                    e = sb.pop_front();
                    if ({cnt_a, lost_a, ovf_a} !== {e.cnt[7:0], e.lost[7:0], e.ovf[0]}) begin
                        n_bad++;
                        $display("FAIL abort_totals: got %0d/%0d/%b want %0d/%0d/%0d", cnt_a, lost_a, ovf_a, e.cnt, e.lost, e.ovf);
                    end
                end
            end
            drive_a(c < 10 || (c >= 15 && c < 31), c == 2 || c == 7 || c == 17 || c == 22 || c == 27);
        end
        idle_a(4);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        sb.push_back('{3, 1, 0});
        sb.push_back('{2, 1, 0});
        for (int c = 0; c <= 33; c++) begin
            n_cmp++;
            if (vld_a !== (c == 16 || c == 32)) begin
                n_bad++;
                $display("FAIL b2b_strobe cyc%0d: got %b want %b", c, vld_a, c == 16 || c == 32);
            end
            if (c == 16 || c == 32) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_sb: got empty queue want entry"); end
                else begin
                    e = sb.pop_front();
                    if ({cnt_a, lost_a, ovf_a} !== {e.cnt[7:0], e.lost[7:0], e.ovf[0]}) begin
                        n_bad++;
                        $display("FAIL b2b_totals cyc%0d: got %0d/%0d/%b want %0d/%0d/%0d", c, cnt_a, lost_a, ovf_a, e.cnt, e.lost, e.ovf);
                    end
                end
            end
            drive_a(c < 32, c == 1 || c == 3 || c == 9 || c == 15 || c == 20 || c == 29 || c == 31);
        end
        idle_a(4);
    endtask

    task automatic test_saturation;
        exp_t e;
        sb.push_back('{15, 0, 1});
        sb.push_back('{0, 0, 0});
        for (int c = 0; c <= 128; c++) begin
            n_cmp++;
            if (vld_b !== (c == 64 || c == 128) || busy_b !== 1'b0) begin
                n_bad++;
                $display("FAIL sat_strobe cyc%0d: got valid=%b busy=%b want valid=%b busy=0", c, vld_b, busy_b, c == 64 || c == 128);
            end
            if (c == 64 || c == 128) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL sat_sb: got empty queue want entry"); end
                else begin
                    e = sb.pop_front();
                    if ({cnt_b, lost_b, ovf_b} !== {e.cnt[3:0], e.lost[3:0], e.ovf[0]}) begin
                        n_bad++;
                        $display("FAIL sat_totals cyc%0d: got %0d/%0d/%b want %0d/%0d/%0d", c, cnt_b, lost_b, ovf_b, e.cnt, e.lost, e.ovf);
                    end
                end
            end
            drive_b(c < 128, c < 64 && (c % 2) == 0);
        end
    endtask

    task automatic test_reset_abort;
        exp_t e;
        sb.push_back('{1, 0, 0});
        for (int c = 0; c <= 22; c++) begin
            n_cmp++;
            if (vld_a !== (c == 22)) begin
                n_bad++;
                $display("FAIL rstab_strobe cyc%0d: got %b want %b", c, vld_a, c == 22);
            end
            if (c >= 6 && c < 22) begin
                n_cmp++;
                if ({cnt_a, lost_a, ovf_a} !== 17'd0) begin
                    n_bad++;
                    $display("FAIL rstab_cleared cyc%0d: got %0d/%0d/%b want 0/0/0", c, cnt_a, lost_a, ovf_a);
                end
            end
            if (c == 22) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL rstab_sb: got empty queue want entry"); end
                else begin
                    e = sb.pop_front();
                    if ({cnt_a, lost_a, ovf_a} !== {e.cnt[7:0], e.lost[7:0], e.ovf[0]}) begin
                        n_bad++;
                        $display("FAIL rstab_totals: got %0d/%0d/%b want %0d/%0d/%0d", cnt_a, lost_a, ovf_a, e.cnt, e.lost, e.ovf);
                    end
                end
            end
            rst = (c == 5);
            drive_a(c < 22, c == 2 || c == 10);
        end
        rst = 1'b0;
    endtask

    initial begin
        en_a = 1'b0; p_a = 1'b0; en_b = 1'b0; p_b = 1'b0; rst = 1'b1;
        test_reset;
        test_basic;
        test_dead_time;
        test_held_pulse;
        test_enable_abort;
        test_back_to_back;
        test_saturation;
        test_reset_abort;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pulse_rate_counter.md
Name: pulse_rate_counter

Overview:
- Downstream consumer of the random pulse generator's `pulse` output; behaves like a Geiger-counter front end.
- Detects rising edges on the incoming pulse stream and applies a non-paralyzable detector dead time.
- Accumulates accepted and lost (dead-time) events over a fixed gate window.
- At the end of each window, publishes both totals with a one-cycle valid strobe and a saturation flag.

Parameters:
- COUNT_W, 16: width of the event accumulators and count outputs.
- GATE_CYCLES, 1000: gate window length in clk cycles; must be ≥ 2.
- DEAD_CYCLES, 4: cycles after an accepted event during which new edges are lost; 0 disables dead time.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: gate enable; windows run only while high.
- pulse_in, input, 1: pulse stream from the generator; may stay high for multiple cycles.
- count_out, output, COUNT_W: accepted-event total of the last completed window.
- lost_out, output, COUNT_W: dead-time-lost event total of the last completed window.
- count_valid, output, 1: one-cycle strobe when count_out, lost_out and overflow update.
- overflow, output, 1: last completed window saturated either accumulator.
- dead_busy, output, 1: high while the dead timer is nonzero.

Behaviour:
- Reset (rst=1 at a clk edge): all registers and all outputs go to 0.
  - This includes pulse_q, dead_cnt, gate_cnt, both accumulators and both overflow sticky bits.
- Edge detect: pulse_q <= pulse_in every cycle. rise = pulse_in & ~pulse_q, combinational, 0-cycle latency.
  - A pulse held high N cycles is one event.
  - pulse_in high on the first cycle after reset is a rise.
- Dead timer runs regardless of enable:
  - If dead_cnt != 0, dead_cnt decrements.
  - An accepted rise loads DEAD_CYCLES.
  - dead_busy = (dead_cnt != 0).
- Event classification, only when enable=1:
  - rise with dead_cnt==0: accepted. acc_cnt increments and the dead timer loads.
  - rise with dead_cnt!=0: lost. acc_lost increments and the dead timer is NOT reloaded (non-paralyzable).
  - Resulting timing: accepted rise at cycle t → rises at t+1..t+DEAD_CYCLES are lost; a rise at t+DEAD_CYCLES+1 is accepted.
- enable=0: rises are neither accepted nor lost and start no dead time. gate_cnt, acc_cnt, acc_lost and the sticky bits are held at 0. Outputs keep their last published values.
- States: IDLE (enable=0) and GATING (enable=1).
  - IDLE→GATING: the first cycle with enable=1 is window cycle 0 (gate_cnt=0).
  - GATING→IDLE: enable falls; the partial window is discarded with no strobe.
- Window close, when gate_cnt == GATE_CYCLES-1 in GATING:
  - count_out <= acc_cnt plus this cycle's accepted event, saturated.
  - lost_out <= acc_lost plus this cycle's lost event, saturated.
  - overflow <= OR of both sticky bits, including a saturation on this cycle.
  - count_valid <= 1 for exactly one cycle.
  - Accumulators and sticky bits clear; gate_cnt <= 0. Windows are back-to-back with no gap cycle.
  - count_valid is asserted in the cycle after the last window cycle.
- Saturation: an increment at all-ones holds at all-ones and sets that accumulator's sticky bit. No wrap-around.
- count_valid is 0 in all other cycles. Outputs change only at window close or reset.
- rst mid-window aborts the window and clears everything; no strobe is issued.
- gate_cnt width = clog2(GATE_CYCLES); wraps only via the close rule above.

Test Plan:
- Reset state:
  - Stimulus: rst=1 for 3 cycles with pulse_in=1 and enable=1.
  - Required: all outputs 0. After release, the first cycle counts a rise: with GATE=16, count_out=1 at the first strobe.
- Basic count (GATE=16, DEAD=3, COUNT_W=8):
  - Stimulus: enable rises at cycle 0; 1-cycle pulses at window cycles 2, 8, 14.
  - Required: count_valid high exactly at cycle 16; count_out=3, lost_out=0, overflow=0.
- Dead time (GATE=16, DEAD=3):
  - Stimulus: 1-cycle pulses at window cycles 0, 2, 4, 15.
  - Required: count_out=3, lost_out=1 (cycle 2). dead_busy is high on cycles 1–3, 5–7 and 16–18. The cycle-15 event lands in the closing window.
- Held pulse:
  - Stimulus: pulse_in high for window cycles 3–9, no other pulses.
  - Required: count_out=1, lost_out=0.
- Saturation (COUNT_W=4, GATE=64, DEAD=0):
  - Stimulus: pulse_in toggles every cycle, giving 32 rises.
  - Required: count_out=15, overflow=1.
  - Next window, with no pulses: count_out=0, overflow=0.
- Enable abort:
  - Stimulus: enable high cycles 0–9 with 2 events, low for 5 cycles, then high again.
  - Required: no strobe at cycle 16. Next strobe comes exactly GATE_CYCLES cycles after re-enable with count_out reflecting only post-re-enable events. Outputs hold prior values meanwhile.
